// File: rtl/btb_pkg.sv
// Shared types, constants and PC slicing helpers for the set-associative BTB.
// Index/tag slicing is parameter-driven so every BTB geometry shares one definition.
package btb_pkg;

  localparam int PC_LSB  = 2;
  localparam int PC_BITS = 64;
  localparam int TAG_MAX = PC_BITS;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [PC_BITS-1:0] dest;
    logic               unconditional;
  } btb_entry_t;

  function automatic int calc_sets(input int entries, input int ways);
    return entries / ways;
  endfunction

  function automatic int calc_idx(input int sets);
    return (sets > 1) ? $clog2(sets) : 0;
  endfunction

  // Index bits sit just above the instruction-alignment bits; zero-width index maps to set 0.
  function automatic logic [PC_BITS-1:0] pc_index(input logic [PC_BITS-1:0] pc, input int idx_bits);
    return (pc >> PC_LSB) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [PC_BITS-1:0] pc_tag(input logic [PC_BITS-1:0] pc, input int idx_bits,
                                                input int tag_bits);
    return (pc >> (PC_LSB + idx_bits)) & ((64'd1 << tag_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/btb_rr_victim.sv
// Victim pick for one set: lowest invalid way, else the round-robin pointer way.
// Combinational, no backpressure; evict flags that the pointer way is being replaced.
module btb_rr_victim #(
  parameter int WAYS = 4,
  parameter int WW   = 2
) (
  input  logic [WAYS-1:0] set_valid,
  input  logic [WW-1:0]   ptr,
  output logic [WW-1:0]   victim,
  output logic            evict,
  output logic [WW-1:0]   ptr_next
);

  always_comb begin
    victim = ptr;
    evict  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        victim = WW'(w);
        evict  = 1'b0;
      end
    end
  end

  assign ptr_next = (ptr == WW'(WAYS - 1)) ? '0 : ptr + WW'(1);

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer, 1-cycle registered lookup, clkEn stalls all state.
// No backpressure; define BTB_FWD_EN to forward a same-edge update/invalidate into the lookup.
module btb_set_assoc
  import btb_pkg::*;
#(
  parameter int ENTRIES  = 256,
  parameter int WAYS     = 4,
  parameter int TAG_BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clkEn,
  input  logic [PC_BITS-1:0] pc,
  input  logic               update,
  input  logic               invalidate,
  input  logic [PC_BITS-1:0] updatePc,
  input  logic [PC_BITS-1:0] destIn,
  input  logic               unconditionalIn,
  output logic [PC_BITS-1:0] destOut,
  output logic               validOut,
  output logic               unconditionalOut
);

  localparam int SETS = calc_sets(ENTRIES, WAYS);
  localparam int IDX  = calc_idx(SETS);
  localparam int IW   = (IDX > 0) ? IDX : 1;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]     vld_q    [SETS];
  logic [WW-1:0]       ptr_q    [SETS];
  logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
  logic [PC_BITS-1:0]  dest_mem [SETS][WAYS];
  logic [WAYS-1:0]     unc_mem  [SETS];

  logic [IW-1:0]       lidx, uidx;
  logic [TAG_BITS-1:0] ltag, utag;

  assign lidx = IW'(pc_index(pc, IDX));
  assign ltag = TAG_BITS'(pc_tag(pc, IDX, TAG_BITS));
  assign uidx = IW'(pc_index(updatePc, IDX));
  assign utag = TAG_BITS'(pc_tag(updatePc, IDX, TAG_BITS));

  btb_entry_t         lk_way [WAYS];
  logic               lk_hit, lk_unc;
  logic [PC_BITS-1:0] lk_dest;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      lk_way[w] = '{valid:         vld_q[lidx][w],
                    tag:           TAG_MAX'(tag_mem[lidx][w]),
                    dest:          dest_mem[lidx][w],
                    unconditional: unc_mem[lidx][w]};
    end
  end

  // Descending scan so the lowest hitting way has the final say.
  always_comb begin
    lk_hit  = 1'b0;
    lk_dest = '0;
    lk_unc  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_way[w].valid && lk_way[w].tag == TAG_MAX'(ltag)) begin
        lk_hit  = 1'b1;
        lk_dest = lk_way[w].dest;
        lk_unc  = lk_way[w].unconditional;
      end
    end
  end

  logic [WAYS-1:0] up_hit_vec;
  logic            up_hit;
  logic [WW-1:0]   up_way;

  always_comb begin
    up_hit_vec = '0;
    up_hit     = 1'b0;
    up_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld_q[uidx][w] && tag_mem[uidx][w] == utag) begin
        up_hit_vec[w] = 1'b1;
        up_hit        = 1'b1;
        up_way        = WW'(w);
      end
    end
  end

  logic [WW-1:0] victim, ptr_next, wr_way;
  logic          evict;

  btb_rr_victim #(
    .WAYS (WAYS),
    .WW   (WW)
  ) u_victim (
    .set_valid (vld_q[uidx]),
    .ptr       (ptr_q[uidx]),
    .victim    (victim),
    .evict     (evict),
    .ptr_next  (ptr_next)
  );

  assign wr_way = up_hit ? up_way : victim;

  logic               nx_vld, nx_unc;
  logic [PC_BITS-1:0] nx_dest;

  always_comb begin
    nx_vld  = lk_hit;
    nx_dest = lk_dest;
    nx_unc  = lk_unc;
`ifdef BTB_FWD_EN
    if (lidx == uidx && ltag == utag) begin
      if (invalidate) begin
        nx_vld  = 1'b0;
        nx_dest = '0;
        nx_unc  = 1'b0;
      end else if (update) begin
        nx_vld  = 1'b1;
        nx_dest = destIn;
        nx_unc  = unconditionalIn;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        ptr_q[s] <= '0;
      end
      validOut         <= 1'b0;
      destOut          <= '0;
      unconditionalOut <= 1'b0;
    end else if (clkEn) begin
      if (invalidate) begin
        vld_q[uidx] <= vld_q[uidx] & ~up_hit_vec;
      end else if (update && !up_hit) begin
        vld_q[uidx][victim] <= 1'b1;
        if (evict) ptr_q[uidx] <= ptr_next;
      end
      validOut         <= nx_vld;
      destOut          <= nx_dest;
      unconditionalOut <= nx_unc;
    end
  end

  // Payload arrays carry no reset; valid bits alone decide whether contents matter.
  always_ff @(posedge clk) begin
    if (!rst && clkEn && update && !invalidate) begin
      tag_mem[uidx][wr_way]  <= utag;
      dest_mem[uidx][wr_way] <= destIn;
      unc_mem[uidx][wr_way]  <= unconditionalIn;
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Self-checking bench for btb_set_assoc: directed scenarios then random traffic
// on a few colliding sets, compared against a way-array reference model.
module tb_btb_set_assoc;

  localparam int ENTRIES = 256;
  localparam int WAYS    = 4;
  localparam int SETS    = ENTRIES / WAYS;
  localparam int IDXB    = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b0;
  logic [63:0] pc = '0;
  logic        update = 1'b0;
  logic        invalidate = 1'b0;
  logic [63:0] updatePc = '0;
  logic [63:0] destIn = '0;
  logic        unconditionalIn = 1'b0;
  logic [63:0] destOut;
  logic        validOut;
  logic        unconditionalOut;

  btb_set_assoc #(.ENTRIES(ENTRIES), .WAYS(WAYS), .TAG_BITS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .clkEn            (clkEn),
    .pc               (pc),
    .update           (update),
    .invalidate       (invalidate),
    .updatePc         (updatePc),
    .destIn           (destIn),
    .unconditionalIn  (unconditionalIn),
    .destOut          (destOut),
    .validOut         (validOut),
    .unconditionalOut (unconditionalOut)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per set, an array of ways plus a replacement counter.
  bit          m_vld  [SETS][WAYS];
  logic [15:0] m_tag  [SETS][WAYS];
  logic [63:0] m_dest [SETS][WAYS];
  bit          m_unc  [SETS][WAYS];
  int          m_ptr  [SETS];

  logic        e_v = 1'b0;
  logic [63:0] e_d = '0;
  logic        e_u = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int set_of(input logic [63:0] p);
    return int'((p / 4) % SETS);
  endfunction

  function automatic logic [15:0] tag_of(input logic [63:0] p);
    return 16'((p / (4 * SETS)) % 65536);
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 0;
    end
  endfunction

  function automatic void m_lookup(input logic [63:0] p, output logic v, output logic [63:0] d,
                                   output logic u);
    int s = set_of(p);
    v = 1'b0; d = '0; u = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_vld[s][w] && m_tag[s][w] == tag_of(p)) begin
        v = 1'b1; d = m_dest[s][w]; u = m_unc[s][w];
        break;
      end
    end
  endfunction

  function automatic void m_update(input logic [63:0] p, input logic [63:0] d, input logic u);
    int s = set_of(p);
    int slot = -1;
    for (int w = 0; w < WAYS; w++)
      if (slot < 0 && m_vld[s][w] && m_tag[s][w] == tag_of(p)) slot = w;
    if (slot < 0)
      for (int w = 0; w < WAYS; w++)
        if (slot < 0 && !m_vld[s][w]) slot = w;
    if (slot < 0) begin
      slot = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_vld[s][slot] = 1; m_tag[s][slot] = tag_of(p);
    m_dest[s][slot] = d; m_unc[s][slot] = u;
  endfunction

  function automatic void m_inval(input logic [63:0] p);
    int s = set_of(p);
    for (int w = 0; w < WAYS; w++)
      if (m_tag[s][w] == tag_of(p)) m_vld[s][w] = 0;
  endfunction

  // One clock: drive inputs, advance the model, then check outputs after the edge.
  task automatic step(input logic [63:0] lpc, input logic up, input logic inv,
                      input logic [63:0] upc, input logic [63:0] d, input logic un,
                      input logic en, input logic r);
    pc = lpc; update = up; invalidate = inv; updatePc = upc;
    destIn = d; unconditionalIn = un; clkEn = en; rst = r;
    if (r) begin
      m_reset();
      e_v = 1'b0; e_d = '0; e_u = 1'b0;
    end else if (en) begin
      m_lookup(lpc, e_v, e_d, e_u);
`ifdef BTB_FWD_EN
      if (set_of(lpc) == set_of(upc) && tag_of(lpc) == tag_of(upc)) begin
        if (inv) begin
          e_v = 1'b0; e_d = '0; e_u = 1'b0;
        end else if (up) begin
          e_v = 1'b1; e_d = d; e_u = un;
        end
      end
`endif
      if (inv) m_inval(upc);
      else if (up) m_update(upc, d, un);
    end
    @(posedge clk);
    #1;
    check("validOut", 64'(validOut), 64'(e_v));
    check("destOut", destOut, e_d);
    check("unconditionalOut", 64'(unconditionalOut), 64'(e_u));
  endtask

  task automatic look(input logic [63:0] lpc);
    step(lpc, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic upd(input logic [63:0] upc, input logic [63:0] d, input logic un);
    step(64'h9990, 1'b1, 1'b0, upc, d, un, 1'b1, 1'b0);
  endtask

  initial begin
    logic [63:0] rp, ru;
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    look(64'h1000);
    check("reset_miss", 64'(validOut), 64'd0);
    upd(64'h1000, 64'h2000, 1'b1);
    look(64'h1000);
    check("hit_dest", destOut, 64'h2000);
    check("hit_uncond", 64'(unconditionalOut), 64'd1);
    look(64'h1004);
    check("neighbour_miss", 64'(validOut), 64'd0);

    // Same-set fill: 0x1000 sits in way 0; 0x1400 evicts it, 0x1500 evicts 0x1100.
    for (int k = 1; k < 6; k++) upd(64'h1000 + 64'(k) * 64'h100, 64'hA000 + 64'(k), 1'b0);
    look(64'h1000);
    check("evict_way0", 64'(validOut), 64'd0);
    look(64'h1100);
    check("evict_way1", 64'(validOut), 64'd0);
    look(64'h1200);
    check("survivor_dest", destOut, 64'hA002);

    step(64'h2400, 1'b1, 1'b1, 64'h2400, 64'h7777, 1'b1, 1'b1, 1'b0);
    look(64'h2400);
    check("upd_inv_miss", 64'(validOut), 64'd0);

    step(64'h9990, 1'b0, 1'b1, 64'h1300, '0, 1'b0, 1'b1, 1'b0);
    look(64'h1300);
    upd(64'h1600, 64'hB600, 1'b0);
    look(64'h1200);
    check("reuse_invalid_way", destOut, 64'hA002);

    look(64'h1200);
    for (int k = 0; k < 3; k++) step(64'h1400, 1'b1, 1'b0, 64'h5000, 64'h5555, 1'b1, 1'b0, 1'b0);
    check("frozen_dest", destOut, 64'hA002);
    look(64'h5000);

    step(64'h3000, 1'b1, 1'b0, 64'h3000, 64'h3ABC, 1'b0, 1'b1, 1'b0);
    look(64'h3000);
    check("fwd_followup", destOut, 64'h3ABC);

    look(64'h1200);
    step(64'h1200, 1'b1, 1'b0, 64'h1700, 64'h1, 1'b0, 1'b1, 1'b1);
    look(64'h1200);
    check("post_reset_miss", 64'(validOut), 64'd0);
    look(64'h3000);

    for (int i = 0; i < 400; i++) begin
      rp = 64'($urandom_range(0, 7)) * 64'h100 + 64'($urandom_range(0, 1)) * 64'h4;
      ru = 64'($urandom_range(0, 7)) * 64'h100 + 64'($urandom_range(0, 1)) * 64'h4;
      step(rp, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0), ru,
           {$urandom, $urandom}, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_set_assoc.md
# btb_set_assoc

Parametrised set-associative branch target buffer for the front end, replacing the stub BTB. Each enabled cycle it looks up the fetch PC and returns a registered prediction one cycle later: target address, hit flag and unconditional flag. The back end trains it with resolved branches and can invalidate entries. Replacement is per-set round-robin.

## Interface
Parameters:
- ENTRIES, 256, total entries; power of two.
- WAYS, 4, associativity; power of two, 1..ENTRIES.
- TAG_BITS, 16, partial tag width; aliasing on partial-tag match is permitted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clkEn  in  1  global enable; when low, all state and outputs hold.
- pc  in  64  fetch PC to look up.
- update  in  1  write/refresh the entry for updatePc.
- invalidate  in  1  clear any entry matching updatePc.
- updatePc  in  64  PC of the resolved branch.
- destIn  in  64  resolved target.
- unconditionalIn  in  1  resolved branch is unconditional.
- destOut  out  64  predicted target.
- validOut  out  1  lookup hit.
- unconditionalOut  out  1  hit entry is unconditional.

## Operation
- SETS = ENTRIES/WAYS, IDX = log2(SETS). Index = pc[2 +: IDX]; tag = pc[2+IDX +: TAG_BITS]. The same slicing applies to updatePc. When IDX = 0 every PC maps to set 0.
- Entry fields: valid, tag, dest[63:0], unconditional. Valid bits and round-robin pointers are held in flops.
- Lookup: compare all ways of the indexed set. Hit = valid && tag match. If several ways hit, the lowest way wins. On a miss, destOut = 0, validOut = 0 and unconditionalOut = 0.
- Update, set hit: overwrite dest and unconditional in the hitting way. The pointer is unchanged.
- Update, set miss: write to the lowest-numbered invalid way. If no way is invalid, write to the way selected by the set pointer, then advance the pointer by 1 mod WAYS. The pointer advances only on eviction.
- Invalidate: clear valid on every matching way of the indexed set. The pointer is unchanged.
- update and invalidate both high: invalidate wins and no write occurs.
- With clkEn low, update and invalidate are ignored and no state changes.
- Reset: all valid bits = 0, all pointers = 0, outputs = 0. The data and tag arrays are not reset.

## Timing
- Lookup latency is 1 cycle. pc sampled at edge t (clkEn = 1) gives outputs after edge t, held until the next enabled edge.
- Updates take effect at the enabled edge t.
- Without forwarding, a lookup sampled at the same edge sees pre-update contents.
- rst at an edge overrides clkEn and any pending update. The cycle after rst shows validOut = 0.
- rst asserted mid-stream: the next lookup misses regardless of history.

## Configuration
- BTB_FWD_EN defined: same-cycle forwarding is enabled. If update (without invalidate) and the lookup share index and tag at the same edge, the outputs reflect destIn/unconditionalIn with validOut = 1. A same-edge invalidate on a matching lookup forces validOut = 0.
- BTB_FWD_EN undefined: no forwarding. The same-edge lookup returns pre-update contents.

## Structure
- btb_pkg holds:
  - the btb_entry_t struct (valid, tag, dest, unconditional);
  - constants PC_LSB = 2 and PC_BITS = 64;
  - functions deriving SETS, IDX and the tag/index slice from the parameters.
- Sub-module btb_rr_victim: per-set victim choice (first-invalid else pointer) plus pointer advance. It is instantiated once on the update port.

## Test plan
- Reset then lookup pc 0x1000 -> validOut = 0, destOut = 0 one cycle later.
- Update pc 0x1000 dest 0x2000 uncond = 1, then lookup 0x1000 next cycle -> validOut = 1, destOut = 0x2000, unconditionalOut = 1. Lookup 0x1004 -> miss.
- WAYS = 4: fill five same-set PCs (stride SETS×4 bytes) -> first four land in ways 0..3. The fifth evicts way 0 and the pointer becomes 1. A sixth evicts way 1.
- Update and invalidate same PC same edge -> entry stays invalid. Invalidate a resident PC -> next lookup misses and its way is reused by the next miss before the pointer way.
- clkEn = 0 for 3 cycles with update pulsed -> outputs frozen and no write. rst during a stream -> all subsequent lookups miss.
- Same-edge update and lookup of 0x3000 -> hit with BTB_FWD_EN, miss without; both builds hit on the following lookup.
